dmem_responder: RTL and testbench

//  Memory-side responder for the CPU data-memory port: services one load/store at a time over a
//  req/ack handshake with a fixed number of wait states. Replaces the zero-latency combinational

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_array.sv | 46 ++++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage: one synchronous write port, one registered read port.
// The read register holds its value between reads; rd_clr_i loads zero instead of memory.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AW-1:0]     idx_i,
    input  logic              wr_en_i,
    input  logic [WORD_W-1:0] wr_dat_i,
    input  logic              rd_en_i,
    input  logic              rd_clr_i,
    output logic [WORD_W-1:0] rd_dat_o
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rd_dat_d, rd_dat_q;

    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en_i) begin
            rd_dat_d = rd_clr_i ? '0 : mem[idx_i];
        end
    end

    // Storage itself is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[idx_i] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with WAIT_CYCLES wait states and a one-cycle ack.
// Optional misalignment error reporting when DMEM_ALIGN_CHECK_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              ack_o,
    output logic [WORD_W-1:0] data_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_t       state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              we_d, we_q;
    logic [AW+1:0]     addr_d, addr_q;
    logic [WORD_W-1:0] data_d, data_q;
    logic              ack_d, ack_q;
    logic              busy_d, busy_q;
    logic              err_d, err_q;

    logic              enter_resp;
    logic              acc_we;
    logic [AW+1:0]     acc_addr;
    logic [WORD_W-1:0] acc_data;
    logic              misaligned;

    // With zero wait states the access happens on the capture edge, so use the live inputs then.
    assign acc_we   = (state_q == IDLE) ? we_i           : we_q;
    assign acc_addr = (state_q == IDLE) ? addr_i[AW+1:0] : addr_q;
    assign acc_data = (state_q == IDLE) ? data_i         : data_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (acc_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d   = we_i;
                    addr_d = addr_i[AW+1:0];
                    data_d = data_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ack_d  = enter_resp;
        err_d  = enter_resp & misaligned;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Reset on the access edge abandons the transaction, so the store must not commit.
    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .idx_i    (acc_addr[AW+1:2]),
        .wr_en_i  (enter_resp & acc_we & ~misaligned & ~rst_i),
        .wr_dat_i (acc_data),
        .rd_en_i  (enter_resp & ~acc_we & ~rst_i),
        .rd_clr_i (misaligned),
        .rd_dat_o (data_o)
    );

    assign ack_o  = ack_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with DEPTH_WORDS=32, WAIT_CYCLES=2.
module tb_dmem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i  = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic        ack_o;
    logic [31:0] data_o;
    logic        busy_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    dmem_responder #(
        .DEPTH_WORDS (32),
        .WAIT_CYCLES (2)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .ack_o  (ack_o),
        .data_o (data_o),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    // Issue one request and watch 8 cycles; reports first ack cycle, ack count, data and err.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] dat,
                        output int ack_cyc, output int n_ack,
                        output logic [31:0] rdat, output logic rerr);
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = addr; data_i = dat;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        ack_cyc = -1; n_ack = 0; rdat = '0; rerr = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            if (ack_o === 1'b1) begin
                n_ack++;
                if (ack_cyc < 0) begin
                    ack_cyc = c; rdat = data_o; rerr = err_o;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({ack_o, busy_o, err_o, data_o} !== 35'd0) begin
            errors++;
            $display("FAIL reset: ack=%b busy=%b err=%b data=%h, want all zero", ack_o, busy_o, err_o, data_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_store_timing();
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h8; data_i = 32'hDEADBEEF;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_i);
            checks++;
            if (ack_o !== (c == 3)) begin
                errors++;
                $display("FAIL store_ack cycle %0d: got %b want %b", c, ack_o, (c == 3));
            end
            checks++;
            if (busy_o !== (c <= 3)) begin
                errors++;
                $display("FAIL store_busy cycle %0d: got %b want %b", c, busy_o, (c <= 3));
            end
        end
    endtask

    task automatic test_load();
        int cyc, n; logic [31:0] d; logic e;
        xact(1'b0, 32'h8, 32'h0, cyc, n, d, e);
        checks++;
        if (cyc !== 3 || n !== 1) begin
            errors++;
            $display("FAIL load_ack: cycle %0d count %0d, want cycle 3 count 1", cyc, n);
        end
        checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL load_data: data %h err %b, want DEADBEEF err 0", d, e);
        end
    endtask

    task automatic test_wrap();
        int cyc, n; logic [31:0] d; logic e;
        xact(1'b1, 32'h80, 32'h11111111, cyc, n, d, e);
        checks++;
        if (cyc !== 3 || e !== 1'b0) begin
            errors++;
            $display("FAIL wrap_store: ack cycle %0d err %b, want 3 and 0", cyc, e);
        end
        checks++;
        if (data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL hold_data: data_o %h after store, want DEADBEEF", data_o);
        end
        xact(1'b0, 32'h0, 32'h0, cyc, n, d, e);
        checks++;
        if (d !== 32'h11111111 || cyc !== 3) begin
            errors++;
            $display("FAIL wrap_load: data %h cycle %0d, want 11111111 cycle 3", d, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int acks[$];
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_i);
            if (ack_o === 1'b1) acks.push_back(c);
        end
        req_i = 1'b0;
        repeat (6) @(negedge clk_i);
        checks++;
        if (acks.size() !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d acks, want 3", acks.size());
        end else begin
            checks++;
            if (acks[0] !== 3 || acks[1] !== 7 || acks[2] !== 11) begin
                errors++;
                $display("FAIL b2b_spacing: acks at %0d %0d %0d, want 3 7 11", acks[0], acks[1], acks[2]);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        int cyc, n, late; logic [31:0] d; logic e;
        xact(1'b1, 32'h20, 32'hAAAA5555, cyc, n, d, e);
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; data_i = 32'h12345678;
        @(posedge clk_i);
        #1 req_i = 1'b0; rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        late = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (ack_o === 1'b1) late++;
        end
        checks++;
        if (late !== 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: %0d acks busy %b, want 0 acks busy 0", late, busy_o);
        end
        xact(1'b0, 32'h20, 32'h0, cyc, n, d, e);
        checks++;
        if (d !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL reset_nocommit: data %h, want AAAA5555", d);
        end
    endtask

    task automatic test_misaligned();
        int cyc, n; logic [31:0] d; logic e;
        logic [31:0] exp_w1, exp_ld6;
        logic        exp_err;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_err = 1'b1; exp_w1 = 32'hCAFEF00D; exp_ld6 = 32'h0;
`else
        exp_err = 1'b0; exp_w1 = 32'h0BADC0DE; exp_ld6 = 32'h0BADC0DE;
`endif
        xact(1'b1, 32'h4, 32'hCAFEF00D, cyc, n, d, e);
        xact(1'b1, 32'h6, 32'h0BADC0DE, cyc, n, d, e);
        checks++;
        if (cyc !== 3 || e !== exp_err) begin
            errors++;
            $display("FAIL mis_store: cycle %0d err %b, want 3 and %b", cyc, e, exp_err);
        end
        xact(1'b0, 32'h4, 32'h0, cyc, n, d, e);
        checks++;
        if (d !== exp_w1 || e !== 1'b0) begin
            errors++;
            $display("FAIL mis_word1: data %h err %b, want %h err 0", d, e, exp_w1);
        end
        xact(1'b0, 32'h6, 32'h0, cyc, n, d, e);
        checks++;
        if (d !== exp_ld6 || e !== exp_err) begin
            errors++;
            $display("FAIL mis_load: data %h err %b, want %h err %b", d, e, exp_ld6, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_store_timing();
        test_load();
        test_wrap();
        test_back_to_back();
        test_reset_mid_store();
        test_misaligned();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
